// File: rtl/id_stage_pipe.sv
// Decode stage: ARM-subset decode, register file with write-through bypass,
// RAW hazard detection and the ID/EXE pipeline register.
module id_stage_pipe #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_REGS   = 15,
   parameter int unsigned REG_ADDR_W = 4,
   parameter int unsigned FWD_EN     = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     pc_in,
   input  logic [31:0]           instruction,
   input  logic                  freeze,
   input  logic                  flush,
   input  logic [3:0]            status_bits,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_dest,
   input  logic [DATA_W-1:0]     wb_value,
   input  logic                  exe_wb_en,
   input  logic                  exe_mem_read,
   input  logic [REG_ADDR_W-1:0] exe_dest,
   input  logic                  mem_wb_en,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   output logic                  hazard,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     pc_out,
   output logic [DATA_W-1:0]     val_rn,
   output logic [DATA_W-1:0]     val_rm,
   output logic [REG_ADDR_W-1:0] src1,
   output logic [REG_ADDR_W-1:0] src2,
   output logic [3:0]            exe_cmd,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  wb_enable,
   output logic                  branch_taken,
   output logic                  status_update,
   output logic                  imm,
   output logic [REG_ADDR_W-1:0] dest_reg,
   output logic [11:0]           shift_operand,
   output logic [23:0]           signed_imm_24
);

   localparam logic [REG_ADDR_W:0] NumRegsW = (REG_ADDR_W + 1)'(NUM_REGS);

   localparam logic [3:0] CmdMov = 4'b0001;
   localparam logic [3:0] CmdMvn = 4'b1001;
   localparam logic [3:0] CmdAdd = 4'b0010;
   localparam logic [3:0] CmdAdc = 4'b0011;
   localparam logic [3:0] CmdSub = 4'b0100;
   localparam logic [3:0] CmdSbc = 4'b0101;
   localparam logic [3:0] CmdAnd = 4'b0110;
   localparam logic [3:0] CmdOrr = 4'b0111;
   localparam logic [3:0] CmdEor = 4'b1000;

   // Instruction fields
   logic [3:0]            cond;
   logic [1:0]            mode;
   logic                  imm_bit;
   logic [3:0]            opcode;
   logic                  s_bit;
   logic [REG_ADDR_W-1:0] rn;
   logic [REG_ADDR_W-1:0] rd;
   logic [REG_ADDR_W-1:0] rm;

   assign cond    = instruction[31:28];
   assign mode    = instruction[27:26];
   assign imm_bit = instruction[25];
   assign opcode  = instruction[24:21];
   assign s_bit   = instruction[20];
   assign rn      = REG_ADDR_W'(instruction[19:16]);
   assign rd      = REG_ADDR_W'(instruction[15:12]);

   // Raw control unit outputs, before condition gating
   logic [3:0] cu_exe_cmd;
   logic       cu_mem_read;
   logic       cu_mem_write;
   logic       cu_wb_en;
   logic       cu_branch;
   logic       cu_status;

   always_comb begin
      cu_exe_cmd   = 4'b0000;
      cu_mem_read  = 1'b0;
      cu_mem_write = 1'b0;
      cu_wb_en     = 1'b0;
      cu_branch    = 1'b0;
      cu_status    = 1'b0;
      case (mode)
         2'b00: begin
            cu_status = s_bit;
            case (opcode)
               4'b1101: begin cu_exe_cmd = CmdMov; cu_wb_en = 1'b1; end
               4'b1111: begin cu_exe_cmd = CmdMvn; cu_wb_en = 1'b1; end
               4'b0100: begin cu_exe_cmd = CmdAdd; cu_wb_en = 1'b1; end
               4'b0101: begin cu_exe_cmd = CmdAdc; cu_wb_en = 1'b1; end
               4'b0010: begin cu_exe_cmd = CmdSub; cu_wb_en = 1'b1; end
               4'b0110: begin cu_exe_cmd = CmdSbc; cu_wb_en = 1'b1; end
               4'b0000: begin cu_exe_cmd = CmdAnd; cu_wb_en = 1'b1; end
               4'b1100: begin cu_exe_cmd = CmdOrr; cu_wb_en = 1'b1; end
               4'b0001: begin cu_exe_cmd = CmdEor; cu_wb_en = 1'b1; end
               4'b1010: cu_exe_cmd = CmdSub;   // CMP: flags only
               4'b1000: cu_exe_cmd = CmdAnd;   // TST: flags only
               default: cu_status = 1'b0;
            endcase
         end
         2'b01: begin
            cu_exe_cmd = CmdAdd;
            if (s_bit) begin
               cu_mem_read = 1'b1;
               cu_wb_en    = 1'b1;
            end else begin
               cu_mem_write = 1'b1;
            end
         end
         2'b10: cu_branch = 1'b1;
         default: cu_branch = 1'b0;
      endcase
   end

   // Condition check against NZCV
   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_ok;

   assign {flag_n, flag_z, flag_c, flag_v} = status_bits;

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         4'b0000: cond_ok = flag_z;
         4'b0001: cond_ok = !flag_z;
         4'b0010: cond_ok = flag_c;
         4'b0011: cond_ok = !flag_c;
         4'b0100: cond_ok = flag_n;
         4'b0101: cond_ok = !flag_n;
         4'b0110: cond_ok = flag_v;
         4'b0111: cond_ok = !flag_v;
         4'b1000: cond_ok = flag_c && !flag_z;
         4'b1001: cond_ok = !flag_c || flag_z;
         4'b1010: cond_ok = (flag_n == flag_v);
         4'b1011: cond_ok = (flag_n != flag_v);
         4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
         4'b1101: cond_ok = flag_z || (flag_n != flag_v);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // A store reads its data register through the second port
   assign rm = cu_mem_write ? rd : REG_ADDR_W'(instruction[3:0]);

   // Register file
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              wb_in_range;

   assign wb_in_range = ({1'b0, wb_dest} < NumRegsW);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en && wb_in_range) begin
         regs[wb_dest] <= wb_value;
      end
   end

   logic [DATA_W-1:0] rd_rn;
   logic [DATA_W-1:0] rd_rm;

   always_comb begin
      rd_rn = '0;
      if ({1'b0, rn} < NumRegsW) begin
         rd_rn = (wb_en && wb_dest == rn) ? wb_value : regs[rn];
      end
   end

   always_comb begin
      rd_rm = '0;
      if ({1'b0, rm} < NumRegsW) begin
         rd_rm = (wb_en && wb_dest == rm) ? wb_value : regs[rm];
      end
   end

   // Hazard detection
   logic use1;
   logic use2;
   logic raw_hit;

   assign use1 = (mode != 2'b10);
   assign use2 = ((mode == 2'b00) && !imm_bit) || cu_mem_write;

   generate
      if (FWD_EN != 0) begin : g_fwd
         // Forwarding covers everything except a load still in EXE
         assign raw_hit = exe_mem_read &&
                          ((use1 && exe_dest == rn) || (use2 && exe_dest == rm));
      end else begin : g_nofwd
         logic hit_rn;
         logic hit_rm;
         assign hit_rn  = (exe_wb_en && exe_dest == rn) || (mem_wb_en && mem_dest == rn);
         assign hit_rm  = (exe_wb_en && exe_dest == rm) || (mem_wb_en && mem_dest == rm);
         assign raw_hit = (use1 && hit_rn) || (use2 && hit_rm);
      end
   endgenerate

   assign hazard = in_valid && raw_hit;

   // ID/EXE pipeline register
   logic load;
   logic bubble;

   assign load   = in_valid && !hazard;
   assign bubble = !rst || flush || (!freeze && !load);

   always_ff @(posedge clk) begin
      if (bubble) begin
         out_valid     <= 1'b0;
         pc_out        <= '0;
         val_rn        <= '0;
         val_rm        <= '0;
         src1          <= '0;
         src2          <= '0;
         exe_cmd       <= '0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         wb_enable     <= 1'b0;
         branch_taken  <= 1'b0;
         status_update <= 1'b0;
         imm           <= 1'b0;
         dest_reg      <= '0;
         shift_operand <= '0;
         signed_imm_24 <= '0;
      end else if (!freeze) begin
         out_valid     <= 1'b1;
         pc_out        <= pc_in;
         val_rn        <= rd_rn;
         val_rm        <= rd_rm;
         src1          <= rn;
         src2          <= rm;
         exe_cmd       <= cond_ok ? cu_exe_cmd : 4'b0000;
         mem_read      <= cond_ok && cu_mem_read;
         mem_write     <= cond_ok && cu_mem_write;
         wb_enable     <= cond_ok && cu_wb_en;
         branch_taken  <= cond_ok && cu_branch;
         status_update <= cond_ok && cu_status;
         imm           <= imm_bit;
         dest_reg      <= rd;
         shift_operand <= instruction[11:0];
         signed_imm_24 <= instruction[23:0];
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: one instance without and one with
// forwarding-aware hazard detection, driven from the same stimulus.
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] pc_in;
   logic [31:0] instruction;
   logic        freeze, flush;
   logic [3:0]  status_bits;
   logic        wb_en;
   logic [3:0]  wb_dest;
   logic [31:0] wb_value;
   logic        exe_wb_en, exe_mem_read, mem_wb_en;
   logic [3:0]  exe_dest, mem_dest;

   logic        d0_hazard, d0_out_valid;
   logic [31:0] d0_pc_out, d0_val_rn, d0_val_rm;
   logic [3:0]  d0_src1, d0_src2, d0_exe_cmd, d0_dest_reg;
   logic        d0_mem_read, d0_mem_write, d0_wb_enable, d0_branch_taken, d0_status_update, d0_imm;
   logic [11:0] d0_shift_operand;
   logic [23:0] d0_signed_imm_24;

   logic        d1_hazard, d1_out_valid;
   logic [31:0] d1_pc_out, d1_val_rn, d1_val_rm;
   logic [3:0]  d1_src1, d1_src2, d1_exe_cmd, d1_dest_reg;
   logic        d1_mem_read, d1_mem_write, d1_wb_enable, d1_branch_taken, d1_status_update, d1_imm;
   logic [11:0] d1_shift_operand;
   logic [23:0] d1_signed_imm_24;

   always #5 clk = ~clk;

   id_stage_pipe #(.DATA_W(32), .NUM_REGS(15), .REG_ADDR_W(4), .FWD_EN(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc_in), .instruction(instruction),
      .freeze(freeze), .flush(flush), .status_bits(status_bits), .wb_en(wb_en),
      .wb_dest(wb_dest), .wb_value(wb_value), .exe_wb_en(exe_wb_en),
      .exe_mem_read(exe_mem_read), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en),
      .mem_dest(mem_dest), .hazard(d0_hazard), .out_valid(d0_out_valid), .pc_out(d0_pc_out),
      .val_rn(d0_val_rn), .val_rm(d0_val_rm), .src1(d0_src1), .src2(d0_src2),
      .exe_cmd(d0_exe_cmd), .mem_read(d0_mem_read), .mem_write(d0_mem_write),
      .wb_enable(d0_wb_enable), .branch_taken(d0_branch_taken),
      .status_update(d0_status_update), .imm(d0_imm), .dest_reg(d0_dest_reg),
      .shift_operand(d0_shift_operand), .signed_imm_24(d0_signed_imm_24)
   );

   id_stage_pipe #(.DATA_W(32), .NUM_REGS(15), .REG_ADDR_W(4), .FWD_EN(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc_in), .instruction(instruction),
      .freeze(freeze), .flush(flush), .status_bits(status_bits), .wb_en(wb_en),
      .wb_dest(wb_dest), .wb_value(wb_value), .exe_wb_en(exe_wb_en),
      .exe_mem_read(exe_mem_read), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en),
      .mem_dest(mem_dest), .hazard(d1_hazard), .out_valid(d1_out_valid), .pc_out(d1_pc_out),
      .val_rn(d1_val_rn), .val_rm(d1_val_rm), .src1(d1_src1), .src2(d1_src2),
      .exe_cmd(d1_exe_cmd), .mem_read(d1_mem_read), .mem_write(d1_mem_write),
      .wb_enable(d1_wb_enable), .branch_taken(d1_branch_taken),
      .status_update(d1_status_update), .imm(d1_imm), .dest_reg(d1_dest_reg),
      .shift_operand(d1_shift_operand), .signed_imm_24(d1_signed_imm_24)
   );

   // ctl = {mem_read, mem_write, wb_enable, branch_taken, status_update, imm}
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] vrn;
      logic [31:0] vrm;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic [3:0]  cmd;
      logic [5:0]  ctl;
      logic [3:0]  dst;
      logic [11:0] sh;
      logic [23:0] si;
   } exp_t;

   localparam exp_t Bubble = '0;
   localparam logic [3:0] Al = 4'hE;
   localparam logic [3:0] OpAdd = 4'b0100;

   exp_t  sb_q[$];
   int    errors = 0;
   int    checks = 0;
   string tag = "init";

   task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic logic [31:0] enc(input logic [3:0] cnd, input logic [1:0] md,
                                       input logic i, input logic [3:0] op, input logic s,
                                       input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [11:0] lo);
      return {cnd, md, i, op, s, rn, rd, lo};
   endfunction

   function automatic exp_t ld(input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] vrn, input logic [31:0] vrm,
                               input logic [3:0] cmd, input logic [5:0] ctl);
      exp_t e;
      e.valid = 1'b1;
      e.pc    = pc;
      e.vrn   = vrn;
      e.vrm   = vrm;
      e.s1    = ins[19:16];
      e.s2    = ctl[4] ? ins[15:12] : ins[3:0];
      e.cmd   = cmd;
      e.ctl   = ctl;
      e.dst   = ins[15:12];
      e.sh    = ins[11:0];
      e.si    = ins[23:0];
      return e;
   endfunction

   // Push what the next edge must produce, then compare once it has happened
   task automatic step(input exp_t e);
      exp_t x;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      check_eq({tag, ".valid"}, d0_out_valid, x.valid);
      check_eq({tag, ".pc"}, d0_pc_out, x.pc);
      check_eq({tag, ".val_rn"}, d0_val_rn, x.vrn);
      check_eq({tag, ".val_rm"}, d0_val_rm, x.vrm);
      check_eq({tag, ".src"}, {d0_src1, d0_src2}, {x.s1, x.s2});
      check_eq({tag, ".exe_cmd"}, d0_exe_cmd, x.cmd);
      check_eq({tag, ".ctl"}, {d0_mem_read, d0_mem_write, d0_wb_enable, d0_branch_taken,
                               d0_status_update, d0_imm}, x.ctl);
      check_eq({tag, ".dest"}, d0_dest_reg, x.dst);
      check_eq({tag, ".fields"}, {d0_shift_operand, d0_signed_imm_24}, {x.sh, x.si});
   endtask

   task automatic idle();
      in_valid = 0; pc_in = 0; instruction = 0; freeze = 0; flush = 0; status_bits = 0;
      wb_en = 0; wb_dest = 0; wb_value = 0; exe_wb_en = 0; exe_mem_read = 0; exe_dest = 0;
      mem_wb_en = 0; mem_dest = 0;
   endtask

   task automatic randomize_inputs();
      in_valid = 1'($urandom); pc_in = $urandom; instruction = $urandom;
      freeze = 1'($urandom); flush = 1'($urandom); status_bits = 4'($urandom);
      wb_en = 1'($urandom); wb_dest = 4'($urandom); wb_value = $urandom;
      exe_wb_en = 1'($urandom); exe_mem_read = 1'($urandom); exe_dest = 4'($urandom);
      mem_wb_en = 1'($urandom); mem_dest = 4'($urandom);
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] ins);
      in_valid = 1; pc_in = pc; instruction = ins;
   endtask

   logic [31:0] ins;
   exp_t        ref_e;

   initial begin
      // Reset with random inputs
      tag = "reset";
      rst = 0;
      for (int i = 0; i < 2; i++) begin
         randomize_inputs();
         step(Bubble);
      end
      rst = 1; idle();
      // Fill every register, then reset again and read them all back
      tag = "fill";
      for (int i = 0; i < 15; i++) begin
         wb_en = 1; wb_dest = 4'(i); wb_value = 32'hA000 + 32'(i);
         step(Bubble);
      end
      tag = "reset2";
      rst = 0;
      for (int i = 0; i < 2; i++) begin
         randomize_inputs();
         step(Bubble);
      end
      rst = 1; idle();
      tag = "rf_clear";
      for (int i = 0; i < 15; i++) begin
         ins = enc(Al, 2'b00, 1'b0, OpAdd, 1'b0, 4'(i), 4'd0, {8'h0, 4'(i)});
         issue(32'(i * 4), ins);
         step(ld(32'(i * 4), ins, 0, 0, 4'b0010, 6'b001000));
      end

      // Write-through bypass, then the stored value
      tag = "bypass";
      ins = enc(Al, 2'b00, 1'b0, OpAdd, 1'b0, 4'd3, 4'd1, 12'h003);
      wb_en = 1; wb_dest = 3; wb_value = 32'h1234;
      issue(32'h40, ins);
      step(ld(32'h40, ins, 32'h1234, 32'h1234, 4'b0010, 6'b001000));
      tag = "stored";
      wb_en = 0;
      step(ld(32'h40, ins, 32'h1234, 32'h1234, 4'b0010, 6'b001000));
      idle();
      wb_en = 1; wb_dest = 7; wb_value = 32'hBEEF;
      step(Bubble);
      idle();
      tag = "two_regs";
      ins = enc(Al, 2'b00, 1'b0, OpAdd, 1'b0, 4'd7, 4'd2, 12'h003);
      issue(32'h44, ins);
      step(ld(32'h44, ins, 32'hBEEF, 32'h1234, 4'b0010, 6'b001000));

      // RAW against EXE on rn
      tag = "raw_exe";
      exe_wb_en = 1; exe_dest = 2;
      ins = enc(Al, 2'b00, 1'b0, OpAdd, 1'b0, 4'd2, 4'd1, 12'h004);
      issue(32'h48, ins);
      #1;
      check_eq("raw_exe.hazard0", d0_hazard, 1'b1);
      check_eq("raw_exe.hazard1", d1_hazard, 1'b0);
      step(Bubble);
      check_eq("raw_exe.fwd_valid", d1_out_valid, 1'b1);
      check_eq("raw_exe.fwd_src1", d1_src1, 4'd2);
      // RAW against MEM on rm
      tag = "raw_mem";
      exe_wb_en = 0; mem_wb_en = 1; mem_dest = 4;
      ins = enc(Al, 2'b00, 1'b0, OpAdd, 1'b0, 4'd3, 4'd1, 12'h004);
      issue(32'h4C, ins);
      #1;
      check_eq("raw_mem.hazard0", d0_hazard, 1'b1);
      check_eq("raw_mem.hazard1", d1_hazard, 1'b0);
      step(Bubble);
      // Immediate operand: the low nibble is not a register read
      tag = "imm_nohaz";
      ins = enc(Al, 2'b00, 1'b1, OpAdd, 1'b0, 4'd3, 4'd1, 12'h004);
      issue(32'h50, ins);
      #1;
      check_eq("imm_nohaz.hazard0", d0_hazard, 1'b0);
      step(ld(32'h50, ins, 32'h1234, 0, 4'b0010, 6'b001001));
      tag = "novalid";
      in_valid = 0;
      instruction = enc(Al, 2'b00, 1'b0, OpAdd, 1'b0, 4'd4, 4'd1, 12'h004);
      #1;
      check_eq("novalid.hazard0", d0_hazard, 1'b0);
      step(Bubble);

      // Load-use on a store's data register
      tag = "load_use";
      idle();
      exe_wb_en = 1; exe_mem_read = 1; exe_dest = 5;
      ins = enc(Al, 2'b01, 1'b0, 4'b1100, 1'b0, 4'd6, 4'd5, 12'h008);
      issue(32'h54, ins);
      #1;
      check_eq("load_use.hazard0", d0_hazard, 1'b1);
      check_eq("load_use.hazard1", d1_hazard, 1'b1);
      step(Bubble);
      check_eq("load_use.fwd_valid", d1_out_valid, 1'b0);
      // Branch reads no registers
      tag = "branch";
      ins = enc(Al, 2'b10, 1'b1, 4'b0000, 1'b0, 4'd5, 4'd0, 12'h005);
      issue(32'h58, ins);
      #1;
      check_eq("branch.hazard1", d1_hazard, 1'b0);
      step(ld(32'h58, ins, 0, 0, 4'b0000, 6'b000101));
      tag = "ldr";
      idle();
      ins = enc(Al, 2'b01, 1'b0, 4'b1100, 1'b1, 4'd3, 4'd8, 12'h010);
      issue(32'h5C, ins);
      step(ld(32'h5C, ins, 32'h1234, 0, 4'b0010, 6'b101000));
      tag = "str";
      ins = enc(Al, 2'b01, 1'b0, 4'b1100, 1'b0, 4'd3, 4'd7, 12'h010);
      issue(32'h60, ins);
      step(ld(32'h60, ins, 32'h1234, 32'hBEEF, 4'b0010, 6'b010000));

      // Condition checks
      tag = "eq_fail";
      ins = enc(4'b0000, 2'b00, 1'b0, OpAdd, 1'b1, 4'd3, 4'd1, 12'h007);
      status_bits = 4'b0000;
      issue(32'h64, ins);
      step(ld(32'h64, ins, 32'h1234, 32'hBEEF, 4'b0000, 6'b000000));
      tag = "eq_pass";
      status_bits = 4'b0100;
      step(ld(32'h64, ins, 32'h1234, 32'hBEEF, 4'b0010, 6'b001010));
      tag = "lt_pass";
      ins = enc(4'b1011, 2'b00, 1'b0, OpAdd, 1'b0, 4'd3, 4'd1, 12'h007);
      status_bits = 4'b1000;
      issue(32'h68, ins);
      step(ld(32'h68, ins, 32'h1234, 32'hBEEF, 4'b0010, 6'b001000));
      tag = "gt_fail";
      ins = enc(4'b1100, 2'b00, 1'b0, OpAdd, 1'b0, 4'd3, 4'd1, 12'h007);
      issue(32'h6C, ins);
      step(ld(32'h6C, ins, 32'h1234, 32'hBEEF, 4'b0000, 6'b000000));
      status_bits = 0;

      // Freeze holds, flush beats freeze
      tag = "ref";
      ins = enc(Al, 2'b00, 1'b0, OpAdd, 1'b0, 4'd7, 4'd9, 12'h003);
      issue(32'h100, ins);
      ref_e = ld(32'h100, ins, 32'hBEEF, 32'h1234, 4'b0010, 6'b001000);
      step(ref_e);
      tag = "freeze";
      freeze = 1;
      for (int i = 0; i < 3; i++) begin
         issue(32'h200 + 32'(i * 4), enc(Al, 2'b01, 1'b0, 4'b0000, 1'b1, 4'(i), 4'd2, 12'h001));
         step(ref_e);
      end
      tag = "flush_freeze";
      flush = 1;
      step(Bubble);
      flush = 0; freeze = 0;
      issue(32'h100, ins);
      step(ref_e);
      tag = "flush";
      flush = 1;
      step(Bubble);
      flush = 0;

      // Out-of-range writeback index is dropped and reads as zero
      tag = "wb15";
      wb_en = 1; wb_dest = 15; wb_value = 32'hDEAD;
      ins = enc(Al, 2'b00, 1'b0, OpAdd, 1'b0, 4'd15, 4'd1, 12'h003);
      issue(32'h110, ins);
      step(ld(32'h110, ins, 0, 32'h1234, 4'b0010, 6'b001000));
      wb_en = 0;
      step(ld(32'h110, ins, 0, 32'h1234, 4'b0010, 6'b001000));

      // Reset during a stall
      tag = "rst_stall";
      rst = 0;
      exe_wb_en = 1; exe_dest = 2;
      ins = enc(Al, 2'b00, 1'b0, OpAdd, 1'b0, 4'd2, 4'd1, 12'h003);
      issue(32'h120, ins);
      #1;
      check_eq("rst_stall.hazard0", d0_hazard, 1'b1);
      step(Bubble);
      rst = 1; idle();
      tag = "post_rst";
      ins = enc(Al, 2'b00, 1'b0, OpAdd, 1'b0, 4'd3, 4'd1, 12'h007);
      issue(32'h124, ins);
      step(ld(32'h124, ins, 0, 0, 4'b0010, 6'b001000));

      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
